// File: rtl/wb_timer_pkg.sv
// Shared register map, CTRL/STATUS bit positions, reset constants and the
// run-state encoding for the wishbone timer.
package wb_timer_pkg;

  localparam logic [2:0] ADR_CTRL     = 3'd0;
  localparam logic [2:0] ADR_STATUS   = 3'd1;
  localparam logic [2:0] ADR_COUNT    = 3'd2;
  localparam logic [2:0] ADR_COMPARE  = 3'd3;
  localparam logic [2:0] ADR_PRESCALE = 3'd4;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_AUTO   = 1;
  localparam int CTRL_IE     = 2;
  localparam int STATUS_PEND = 0;

  localparam logic        RST_AUTO     = 1'b0;
  localparam logic        RST_IE       = 1'b0;
  localparam logic        RST_PEND     = 1'b0;
  localparam logic [31:0] RST_COUNT    = 32'h0000_0000;
  localparam logic [31:0] RST_COMPARE  = 32'hFFFF_FFFF;
  localparam logic [31:0] RST_PRESCALE = 32'h0000_0000;

  typedef enum logic {
    ST_STOPPED = 1'b0,
    ST_RUNNING = 1'b1
  } run_state_e;

  // Replace only the bytes of old_v whose select bit is set.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  sel);
    logic [31:0] res;
    res = old_v;
    for (int i = 0; i < 4; i++) begin
      if (sel[i]) res[8*i +: 8] = new_v[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/wb_timer_core.sv
// Prescaler, COUNT register and STOPPED/RUNNING state machine of the timer.
// state       | meaning
// ST_STOPPED  | EN=0, no tick, prescaler and COUNT frozen
// ST_RUNNING  | EN=1, prescaler counts, COUNT advances on each tick
module wb_timer_core
  import wb_timer_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int PRE_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ctrl_wr_i,
  input  logic             en_wdata_i,
  input  logic             auto_i,
  input  logic [CNT_W-1:0] compare_i,
  input  logic [PRE_W-1:0] prescale_i,
  input  logic             cnt_wr_i,
  input  logic [CNT_W-1:0] cnt_wdata_i,
  output logic             running_o,
  output logic [CNT_W-1:0] count_o,
  output logic             match_o
);

  run_state_e       state_q, state_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             tick;
  logic             match;

  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    count_d = count_q;
    tick    = 1'b0;

    // >= rather than == so a PRESCALE lowered below the live count still ticks promptly.
    if (state_q == ST_RUNNING) begin
      if (pre_q >= prescale_i) begin
        tick  = 1'b1;
        pre_d = '0;
      end else begin
        pre_d = pre_q + 1'b1;
      end
    end

    match = tick && (count_q == compare_i);

    if (tick) begin
      if (match) begin
        if (auto_i) count_d = '0;
        else        state_d = ST_STOPPED;
      end else begin
        count_d = count_q + 1'b1;
      end
    end

    if (cnt_wr_i) count_d = cnt_wdata_i;

    if (ctrl_wr_i) begin
      if (en_wdata_i) begin
        state_d = ST_RUNNING;
        if (state_q == ST_STOPPED) pre_d = '0;
      end else begin
        state_d = ST_STOPPED;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_STOPPED;
      pre_q   <= '0;
      count_q <= CNT_W'(RST_COUNT);
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      count_q <= count_d;
    end
  end

  assign running_o = (state_q == ST_RUNNING);
  assign count_o   = count_q;
  assign match_o   = match;

endmodule

// File: rtl/wb_timer.sv
// Wishbone-attached timer: bus decode, register file and interrupt output;
// the counting datapath lives in wb_timer_core.
module wb_timer
  import wb_timer_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int PRE_W = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [2:0]  wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic        irq_o
);

  logic             auto_q, auto_d;
  logic             ie_q, ie_d;
  logic             pend_q, pend_d;
  logic [CNT_W-1:0] compare_q, compare_d;
  logic [PRE_W-1:0] prescale_q, prescale_d;
  logic             ack_q, ack_d;
  logic             err_q, err_d;
  logic             irq_q, irq_d;
  logic [31:0]      dat_q, dat_d;

  logic             req, mapped, wr_en;
  logic             ctrl_wr, cnt_wr, w1c;
  logic [CNT_W-1:0] cnt_wdata;
  logic [31:0]      rd_data;
  logic             running, match;
  logic [CNT_W-1:0] count;

  wb_timer_core #(
    .CNT_W(CNT_W),
    .PRE_W(PRE_W)
  ) u_core (
    .clk        (wb_clk_i),
    .rst        (wb_rst_i),
    .ctrl_wr_i  (ctrl_wr),
    .en_wdata_i (wb_dat_i[CTRL_EN]),
    .auto_i     (auto_q),
    .compare_i  (compare_q),
    .prescale_i (prescale_q),
    .cnt_wr_i   (cnt_wr),
    .cnt_wdata_i(cnt_wdata),
    .running_o  (running),
    .count_o    (count),
    .match_o    (match)
  );

  // A pending ack/err blocks sampling, so a held strobe is served every other cycle.
  always_comb begin
    req       = wb_cyc_i & wb_stb_i & ~ack_q & ~err_q;
    mapped    = (wb_adr_i <= ADR_PRESCALE);
    wr_en     = req & mapped & wb_we_i;
    ctrl_wr   = wr_en && (wb_adr_i == ADR_CTRL) && wb_sel_i[0];
    cnt_wr    = wr_en && (wb_adr_i == ADR_COUNT) && (|wb_sel_i);
    w1c       = wr_en && (wb_adr_i == ADR_STATUS) && wb_sel_i[0] && wb_dat_i[STATUS_PEND];
    cnt_wdata = CNT_W'(byte_merge(32'(count), wb_dat_i, wb_sel_i));
  end

  always_comb begin
    rd_data = '0;
    case (wb_adr_i)
      ADR_CTRL: begin
        rd_data[CTRL_EN]   = running;
        rd_data[CTRL_AUTO] = auto_q;
        rd_data[CTRL_IE]   = ie_q;
      end
      ADR_STATUS:   rd_data[STATUS_PEND] = pend_q;
      ADR_COUNT:    rd_data = 32'(count);
      ADR_COMPARE:  rd_data = 32'(compare_q);
      ADR_PRESCALE: rd_data = 32'(prescale_q);
      default:      rd_data = '0;
    endcase
  end

  always_comb begin
    auto_d     = auto_q;
    ie_d       = ie_q;
    compare_d  = compare_q;
    prescale_d = prescale_q;

    if (ctrl_wr) begin
      auto_d = wb_dat_i[CTRL_AUTO];
      ie_d   = wb_dat_i[CTRL_IE];
    end
    if (wr_en && (wb_adr_i == ADR_COMPARE)) begin
      compare_d = CNT_W'(byte_merge(32'(compare_q), wb_dat_i, wb_sel_i));
    end
    if (wr_en && (wb_adr_i == ADR_PRESCALE)) begin
      prescale_d = PRE_W'(byte_merge(32'(prescale_q), wb_dat_i, wb_sel_i));
    end

    // A match wins over a same-cycle write-1-clear.
    pend_d = pend_q;
    if (w1c)   pend_d = 1'b0;
    if (match) pend_d = 1'b1;

    irq_d = pend_d & ie_d;
    ack_d = req & mapped;
    err_d = req & ~mapped;
    dat_d = (req & mapped & ~wb_we_i) ? rd_data : 32'h0;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      auto_q     <= RST_AUTO;
      ie_q       <= RST_IE;
      pend_q     <= RST_PEND;
      compare_q  <= CNT_W'(RST_COMPARE);
      prescale_q <= PRE_W'(RST_PRESCALE);
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      irq_q      <= 1'b0;
      dat_q      <= 32'h0;
    end else begin
      auto_q     <= auto_d;
      ie_q       <= ie_d;
      pend_q     <= pend_d;
      compare_q  <= compare_d;
      prescale_q <= prescale_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      irq_q      <= irq_d;
      dat_q      <= dat_d;
    end
  end

  assign wb_dat_o = dat_q;
  assign wb_ack_o = ack_q;
  assign wb_err_o = err_q;
  assign irq_o    = irq_q;

endmodule

// File: tb/tb_wb_timer.sv
// Directed bench for wb_timer: register-map vector table plus cycle-exact
// sequences for counting, auto-stop, priority and reset corner cases.
module tb_wb_timer;

  logic        clk;
  logic        rst;
  logic [2:0]  adr;
  logic [31:0] dat_i;
  logic [3:0]  sel;
  logic        we;
  logic        cyc;
  logic        stb;
  logic [31:0] dat_o;
  logic        ack;
  logic        err;
  logic        irq;

  int checks = 0;
  int passes = 0;

  wb_timer dut (
    .wb_clk_i(clk),
    .wb_rst_i(rst),
    .wb_adr_i(adr),
    .wb_dat_i(dat_i),
    .wb_sel_i(sel),
    .wb_we_i (we),
    .wb_cyc_i(cyc),
    .wb_stb_i(stb),
    .wb_dat_o(dat_o),
    .wb_ack_o(ack),
    .wb_err_o(err),
    .irq_o   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        we;
    logic [2:0]  adr;
    logic [3:0]  sel;
    logic [31:0] dat;
    logic        exp_ack;
    logic [31:0] exp_dat;
  } vec_t;

  vec_t tbl [34];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    else passes++;
  endtask

  // One bus transaction, driven right after a clock edge; returns once ack or err is seen.
  task automatic bus(input logic bwe, input logic [2:0] badr, input logic [3:0] bsel,
                     input logic [31:0] bdat, output logic [31:0] rdat,
                     output logic back, output logic berr);
    int n;
    cyc = 1'b1; stb = 1'b1; we = bwe; adr = badr; sel = bsel; dat_i = bdat;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!ack && !err && n < 8);
    back = ack; berr = err; rdat = dat_o;
    cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; dat_i = 32'h0;
    if (!back && !berr) begin
      checks++;
      $display("FAIL bus_timeout: no ack/err on index %0d within 8 cycles", badr);
    end
  endtask

  task automatic wr(input logic [2:0] wadr, input logic [31:0] wdat);
    logic [31:0] r; logic a, e;
    bus(1'b1, wadr, 4'hF, wdat, r, a, e);
  endtask

  task automatic rd(input logic [2:0] radr, output logic [31:0] rdat);
    logic a, e;
    bus(1'b0, radr, 4'hF, 32'h0, rdat, a, e);
  endtask

  logic [31:0] r;
  logic        a, e;

  initial begin
    rst = 1'b1; adr = 3'd0; dat_i = 32'h0; sel = 4'h0; we = 1'b0; cyc = 1'b0; stb = 1'b0;

    tbl = '{
      '{1'b0, 3'd0, 4'hF, 32'h0000_0000, 1'b1, 32'h0000_0000},
      '{1'b0, 3'd1, 4'hF, 32'h0000_0000, 1'b1, 32'h0000_0000},
      '{1'b0, 3'd2, 4'hF, 32'h0000_0000, 1'b1, 32'h0000_0000},
      '{1'b0, 3'd3, 4'hF, 32'h0000_0000, 1'b1, 32'hFFFF_FFFF},
      '{1'b0, 3'd4, 4'hF, 32'h0000_0000, 1'b1, 32'h0000_0000},
      '{1'b1, 3'd3, 4'h2, 32'hAABB_CCDD, 1'b1, 32'h0000_0000},
      '{1'b0, 3'd3, 4'hF, 32'h0000_0000, 1'b1, 32'hFFFF_CCFF},
      '{1'b1, 3'd4, 4'hF, 32'h1234_5678, 1'b1, 32'h0000_0000},
      '{1'b0, 3'd4, 4'hF, 32'h0000_0000, 1'b1, 32'h0000_5678},
      '{1'b1, 3'd4, 4'h4, 32'h00FF_0000, 1'b1, 32'h0000_0000},
      '{1'b0, 3'd4, 4'hF, 32'h0000_0000, 1'b1, 32'h0000_5678},
      '{1'b1, 3'd4, 4'h2, 32'h0000_AB00, 1'b1, 32'h0000_0000},
      '{1'b0, 3'd4, 4'hF, 32'h0000_0000, 1'b1, 32'h0000_AB78},
      '{1'b0, 3'd5, 4'hF, 32'h0000_0000, 1'b0, 32'h0000_0000},
      '{1'b1, 3'd7, 4'hF, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000},
      '{1'b0, 3'd6, 4'hF, 32'h0000_0000, 1'b0, 32'h0000_0000},
      '{1'b0, 3'd4, 4'hF, 32'h0000_0000, 1'b1, 32'h0000_AB78},
      '{1'b1, 3'd0, 4'h1, 32'h0000_0006, 1'b1, 32'h0000_0000},
      '{1'b0, 3'd0, 4'hF, 32'h0000_0000, 1'b1, 32'h0000_0006},
      '{1'b1, 3'd0, 4'hE, 32'h0000_00FF, 1'b1, 32'h0000_0000},
      '{1'b0, 3'd0, 4'hF, 32'h0000_0000, 1'b1, 32'h0000_0006},
      '{1'b1, 3'd0, 4'h1, 32'h0000_0000, 1'b1, 32'h0000_0000},
      '{1'b0, 3'd0, 4'hF, 32'h0000_0000, 1'b1, 32'h0000_0000},
      '{1'b1, 3'd2, 4'h3, 32'h0000_1234, 1'b1, 32'h0000_0000},
      '{1'b0, 3'd2, 4'hF, 32'h0000_0000, 1'b1, 32'h0000_1234},
      '{1'b1, 3'd2, 4'h8, 32'hAB00_0000, 1'b1, 32'h0000_0000},
      '{1'b0, 3'd2, 4'hF, 32'h0000_0000, 1'b1, 32'hAB00_1234},
      '{1'b1, 3'd1, 4'hF, 32'h0000_0001, 1'b1, 32'h0000_0000},
      '{1'b0, 3'd1, 4'hF, 32'h0000_0000, 1'b1, 32'h0000_0000},
      '{1'b1, 3'd3, 4'hF, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000},
      '{1'b0, 3'd3, 4'hF, 32'h0000_0000, 1'b1, 32'hFFFF_FFFF},
      '{1'b1, 3'd4, 4'hF, 32'h0000_0000, 1'b1, 32'h0000_0000},
      '{1'b1, 3'd2, 4'hF, 32'h0000_0000, 1'b1, 32'h0000_0000},
      '{1'b0, 3'd2, 4'hF, 32'h0000_0000, 1'b1, 32'h0000_0000}
    };

    // Outputs held low during reset
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", {31'b0, ack}, 32'h0);
    chk("rst_err", {31'b0, err}, 32'h0);
    chk("rst_irq", {31'b0, irq}, 32'h0);
    chk("rst_dat", dat_o, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // Register map, byte lanes, unmapped indices
    for (int i = 0; i < 34; i++) begin
      bus(tbl[i].we, tbl[i].adr, tbl[i].sel, tbl[i].dat, r, a, e);
      chk($sformatf("vec%0d_ack", i), {31'b0, a}, {31'b0, tbl[i].exp_ack});
      chk($sformatf("vec%0d_err", i), {31'b0, e}, {31'b0, ~tbl[i].exp_ack});
      chk($sformatf("vec%0d_dat", i), r, tbl[i].exp_dat);
    end

    // Auto-reload: PRESCALE=0, COMPARE=3, CTRL=EN|AUTO|IE
    wr(3'd3, 32'd3); wr(3'd4, 32'd0); wr(3'd2, 32'd0); wr(3'd1, 32'd1);
    wr(3'd0, 32'h7);
    repeat (3) @(posedge clk);
    #1 chk("auto_irq_before_match", {31'b0, irq}, 32'h0);
    @(posedge clk);
    #1 chk("auto_irq_at_match", {31'b0, irq}, 32'h1);
    rd(3'd2, r);
    chk("auto_count_reloaded", r, 32'h0);
    wr(3'd1, 32'h1);
    chk("auto_irq_cleared", {31'b0, irq}, 32'h0);
    @(posedge clk);
    #1 chk("auto_irq_second_match", {31'b0, irq}, 32'h1);
    wr(3'd0, 32'h0);

    // Auto-stop: AUTO=0, COMPARE=2, PRESCALE=1
    wr(3'd2, 32'd0); wr(3'd3, 32'd2); wr(3'd4, 32'd1); wr(3'd1, 32'd1);
    wr(3'd0, 32'h5);
    repeat (5) @(posedge clk);
    #1 chk("stop_irq_cycle5", {31'b0, irq}, 32'h0);
    @(posedge clk);
    #1 chk("stop_irq_cycle6", {31'b0, irq}, 32'h1);
    rd(3'd0, r);
    chk("stop_ctrl_en_clear", r, 32'h4);
    rd(3'd2, r);
    chk("stop_count_holds", r, 32'h2);
    repeat (10) @(posedge clk);
    #1 chk("stop_irq_sticky", {31'b0, irq}, 32'h1);
    rd(3'd1, r);
    chk("stop_status_pend", r, 32'h1);
    wr(3'd1, 32'h1);
    chk("stop_irq_w1c", {31'b0, irq}, 32'h0);

    // Write-1-clear in the same cycle as a match
    wr(3'd2, 32'd0); wr(3'd3, 32'd3); wr(3'd4, 32'd0);
    wr(3'd0, 32'h7);
    repeat (3) @(posedge clk);
    #1 chk("w1c_irq_before", {31'b0, irq}, 32'h0);
    wr(3'd1, 32'h1);
    chk("w1c_vs_match_irq", {31'b0, irq}, 32'h1);
    wr(3'd0, 32'h0);
    rd(3'd1, r);
    chk("w1c_vs_match_pend", r, 32'h1);
    wr(3'd1, 32'h1);

    // COUNT write on a tick cycle; PRESCALE=1 ticks on every second edge after enable
    wr(3'd3, 32'hFFFF_0000); wr(3'd4, 32'd1); wr(3'd2, 32'd0);
    wr(3'd0, 32'h1);
    wr(3'd2, 32'h10);
    rd(3'd2, r);
    chk("cnt_write_beats_tick", r, 32'h10);
    wr(3'd0, 32'h0);

    // Held strobe on COUNT: ack every other cycle, data only with ack
    wr(3'd2, 32'h55);
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 3'd2; sel = 4'hF;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk($sformatf("held_ack%0d", i), {31'b0, ack}, (i % 2 == 0) ? 32'h1 : 32'h0);
      chk($sformatf("held_dat%0d", i), dat_o, (i % 2 == 0) ? 32'h55 : 32'h0);
    end
    cyc = 1'b0; stb = 1'b0;
    @(posedge clk); #1;

    // Asynchronous reset mid-count with a bus cycle in flight
    wr(3'd2, 32'd0); wr(3'd3, 32'd5); wr(3'd4, 32'd0); wr(3'd1, 32'd1);
    wr(3'd0, 32'h7);
    repeat (8) @(posedge clk);
    #1 chk("rst_pre_irq", {31'b0, irq}, 32'h1);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 3'd2; sel = 4'hF;
    @(posedge clk);
    #1 chk("rst_pre_ack", {31'b0, ack}, 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_ack", {31'b0, ack}, 32'h0);
    chk("async_rst_err", {31'b0, err}, 32'h0);
    chk("async_rst_irq", {31'b0, irq}, 32'h0);
    chk("async_rst_dat", dat_o, 32'h0);
    repeat (2) @(posedge clk);
    #1 cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk($sformatf("post_rst_no_ack%0d", i), {31'b0, ack}, 32'h0);
    end
    rd(3'd0, r); chk("post_rst_ctrl", r, 32'h0);
    rd(3'd1, r); chk("post_rst_status", r, 32'h0);
    rd(3'd2, r); chk("post_rst_count", r, 32'h0);
    rd(3'd3, r); chk("post_rst_compare", r, 32'hFFFF_FFFF);
    rd(3'd4, r); chk("post_rst_prescale", r, 32'h0);
    chk("post_rst_irq", {31'b0, irq}, 32'h0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
